// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, keeps several imem reads in flight, and queues {pc, word} for ID.
// Define IF_FETCH_BYPASS_EN to let a response reach ID in the same cycle it returns when the queue is empty.
module if_fetch_queue #(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       INST_W    = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       PC_INCR   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc_incr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] word;
  } entry_t;

  entry_t            q [DEPTH];
  logic [ADDR_W-1:0] fetch_pc, rsp_pc, target;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, outst, drop;
  logic              redirect, fire, rsp_vld, rsp_keep, byp, push, pop;
  entry_t            head, rsp, out_ent;

  assign redirect = pc_src != 2'b00;
  assign target   = pc_src[1] ? jr_target : br_target;

  // A response with nothing outstanding (e.g. arriving after reset) is ignored outright.
  assign rsp_vld  = imem_rvalid && (outst != '0);
  assign rsp_keep = rsp_vld && (drop == '0) && !redirect && !rst;
  assign rsp      = {rsp_pc, imem_rdata};
  assign head     = q[rd_ptr];

`ifdef IF_FETCH_BYPASS_EN
  assign byp = rsp_keep && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign inst_valid   = (count != '0) || byp;
  assign out_ent      = (count != '0) ? head : (byp ? rsp : '0);
  assign inst_pc      = out_ent.pc;
  assign inst         = out_ent.word;
  assign inst_pc_incr = inst_pc + INCR;

  assign pop  = (count != '0) && inst_ready && !redirect;
  assign push = rsp_keep && !(byp && inst_ready);

  // Every in-flight read already owns a queue slot, so a push can never find the queue full.
  assign imem_req  = !rst && !redirect && (outst < CW'(MAX_OUTST)) &&
                     (({1'b0, count} + {1'b0, outst}) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc <= target;
      rsp_pc   <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outst    <= outst - CW'(rsp_vld);
      drop     <= outst - CW'(rsp_vld);
    end else begin
      if (fire)                    fetch_pc <= fetch_pc + INCR;
      if (rsp_keep)                rsp_pc   <= rsp_pc + INCR;
      if (rsp_vld && drop != '0)   drop     <= drop - CW'(1);
      if (push)                    wr_ptr   <= wr_ptr + PW'(1);
      if (pop)                     rd_ptr   <= rd_ptr + PW'(1);
      outst <= outst + CW'(fire) - CW'(rsp_vld);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= rsp;
  end

endmodule
